// File: rtl/reg_bank_io_pkg.sv
// Shared decoder codes and flag definitions for the register bank / I/O stage.
// The same constants are used by the sequencing state machine.
package reg_bank_io_pkg;

  localparam int unsigned DECO_BITS = 3;
  localparam int unsigned NUM_REGS  = 6;

  localparam logic [DECO_BITS-1:0] DECO_R0      = 3'b000;
  localparam logic [DECO_BITS-1:0] DECO_R1      = 3'b001;
  localparam logic [DECO_BITS-1:0] DECO_R2      = 3'b010;
  localparam logic [DECO_BITS-1:0] DECO_R3      = 3'b011;
  localparam logic [DECO_BITS-1:0] DECO_R4      = 3'b100;
  localparam logic [DECO_BITS-1:0] DECO_R5      = 3'b101;
  localparam logic [DECO_BITS-1:0] DECO_P0      = 3'b110;
  localparam logic [DECO_BITS-1:0] DECO_P1      = 3'b111;
  localparam logic [DECO_BITS-1:0] DECO_PORTOUT = 3'b110;
  localparam logic [DECO_BITS-1:0] DECO_NOWRITE = 3'b111;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } flags_t;

  localparam flags_t FLAGS_RST = '{overflow: 1'b0, carry: 1'b0, negative: 1'b0, zero: 1'b1};

endpackage

// File: rtl/reg_bank_io_if.sv
// Bus bundle between the sequencing state machine / ALU (master) and the register bank (slave).
interface reg_bank_io_if #(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONDECO = 3
);
  logic [SELECTIONDECO-1:0] sSelDecoA;
  logic [SELECTIONDECO-1:0] sSelDecoB;
  logic [SELECTIONDECO-1:0] sSelDecoC;
  logic [DATAWIDTH-1:0]     iPort0;
  logic [DATAWIDTH-1:0]     iPort1;
  logic [DATAWIDTH-1:0]     iAluResult;
  logic                     iAluOverflow;
  logic                     iAluCarry;
  logic                     iAluNegative;
  logic                     iAluZero;
  logic [DATAWIDTH-1:0]     oBusA;
  logic [DATAWIDTH-1:0]     oBusB;
  logic [DATAWIDTH-1:0]     oPortOut;
  logic                     oPortValid;
  logic                     sOverflow;
  logic                     sCarry;
  logic                     sNegative;
  logic                     sZero;

  modport master (
    output sSelDecoA, sSelDecoB, sSelDecoC, iPort0, iPort1, iAluResult,
           iAluOverflow, iAluCarry, iAluNegative, iAluZero,
    input  oBusA, oBusB, oPortOut, oPortValid, sOverflow, sCarry, sNegative, sZero
  );

  modport slave (
    input  sSelDecoA, sSelDecoB, sSelDecoC, iPort0, iPort1, iAluResult,
           iAluOverflow, iAluCarry, iAluNegative, iAluZero,
    output oBusA, oBusB, oPortOut, oPortValid, sOverflow, sCarry, sNegative, sZero
  );
endinterface

// File: rtl/reg_bank_io_readmux.sv
// Combinational operand read mux: R0..R5, then the two external input ports.
module reg_bank_readmux
  import reg_bank_io_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONDECO = 3
) (
  input  logic [NUM_REGS-1:0][DATAWIDTH-1:0] regs_i,
  input  logic [DATAWIDTH-1:0]               port0_i,
  input  logic [DATAWIDTH-1:0]               port1_i,
  input  logic [SELECTIONDECO-1:0]           sel_i,
  output logic [DATAWIDTH-1:0]               bus_o
);

  logic in_range;

  // Codes above 3'b111 only exist for wider selects; they read zero.
  generate
    if (SELECTIONDECO > DECO_BITS) begin : g_wide
      assign in_range = (sel_i[SELECTIONDECO-1:DECO_BITS] == '0);
    end else begin : g_narrow
      assign in_range = 1'b1;
    end
  endgenerate

  always_comb begin
    bus_o = '0;
    if (in_range) begin
      case (sel_i[DECO_BITS-1:0])
        DECO_P0: bus_o = port0_i;
        DECO_P1: bus_o = port1_i;
        default: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel_i[DECO_BITS-1:0] == DECO_BITS'(i)) bus_o = regs_i[i];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_bank_io.sv
// Register bank with writeback decode, registered ALU flags and a strobed output port.
module reg_bank_io
  import reg_bank_io_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONDECO = 3
) (
  input  logic          clk,
  input  logic          lowRst,
  reg_bank_io_if.slave  bus
);

  logic [NUM_REGS-1:0][DATAWIDTH-1:0] regs_q, regs_d;
  logic [DATAWIDTH-1:0]               port_q, port_d;
  logic                               valid_q, valid_d;
  flags_t                             flags_q, flags_d;
  logic                               wr_in_range;
  logic [DECO_BITS-1:0]               c_lo;

  assign c_lo = bus.sSelDecoC[DECO_BITS-1:0];

  generate
    if (SELECTIONDECO > DECO_BITS) begin : g_wide
      assign wr_in_range = (bus.sSelDecoC[SELECTIONDECO-1:DECO_BITS] == '0);
    end else begin : g_narrow
      assign wr_in_range = 1'b1;
    end
  endgenerate

  always_comb begin
    regs_d  = regs_q;
    port_d  = port_q;
    valid_d = 1'b0;
    flags_d = flags_q;
    if (wr_in_range) begin
      case (c_lo)
        DECO_PORTOUT: begin
          port_d  = bus.iAluResult;
          valid_d = 1'b1;
        end
        DECO_NOWRITE: ;
        default: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (c_lo == DECO_BITS'(i)) regs_d[i] = bus.iAluResult;
          end
        end
      endcase
      if (c_lo != DECO_NOWRITE) begin
        flags_d = '{overflow: bus.iAluOverflow, carry: bus.iAluCarry,
                    negative: bus.iAluNegative, zero: bus.iAluZero};
      end
    end
  end

  always_ff @(posedge clk or negedge lowRst) begin
    if (!lowRst) begin
      regs_q  <= '0;
      port_q  <= '0;
      valid_q <= 1'b0;
      flags_q <= FLAGS_RST;
    end else begin
      regs_q  <= regs_d;
      port_q  <= port_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  reg_bank_readmux #(.DATAWIDTH(DATAWIDTH), .SELECTIONDECO(SELECTIONDECO)) u_mux_a (
    .regs_i (regs_q),
    .port0_i(bus.iPort0),
    .port1_i(bus.iPort1),
    .sel_i  (bus.sSelDecoA),
    .bus_o  (bus.oBusA)
  );

  reg_bank_readmux #(.DATAWIDTH(DATAWIDTH), .SELECTIONDECO(SELECTIONDECO)) u_mux_b (
    .regs_i (regs_q),
    .port0_i(bus.iPort0),
    .port1_i(bus.iPort1),
    .sel_i  (bus.sSelDecoB),
    .bus_o  (bus.oBusB)
  );

  assign bus.oPortOut   = port_q;
  assign bus.oPortValid = valid_q;
  assign bus.sOverflow  = flags_q.overflow;
  assign bus.sCarry     = flags_q.carry;
  assign bus.sNegative  = flags_q.negative;
  assign bus.sZero      = flags_q.zero;

endmodule

// File: tb/tb_reg_bank_io.sv
// Vector table plus a behavioural model; registered outputs are checked through a scoreboard queue.
module tb_reg_bank_io;

  logic clk = 1'b0;
  logic lowRst = 1'b0;
  always #5 clk = ~clk;

  reg_bank_io_if #(.DATAWIDTH(8), .SELECTIONDECO(3)) bus ();

  reg_bank_io #(.DATAWIDTH(8), .SELECTIONDECO(3)) dut (
    .clk   (clk),
    .lowRst(lowRst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] a, b, c;
    logic [7:0] p0, p1, res;
    logic [3:0] fl;  // {overflow, carry, negative, zero}
  } vec_t;

  typedef struct {
    logic [7:0] port;
    logic       valid;
    logic [3:0] flags;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total    = 0;

  logic [7:0] m_regs [6];
  logic [7:0] m_port;
  logic       m_valid;
  logic [3:0] m_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] s, input logic [7:0] p0,
                                        input logic [7:0] p1);
    if (s == 3'b110) return p0;
    if (s == 3'b111) return p1;
    return m_regs[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
    m_port  = 8'h00;
    m_valid = 1'b0;
    m_flags = 4'b0001;
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero};
  endfunction

  // Called ~1 time unit after a rising edge; returns at the same phase one cycle later.
  task automatic step(input vec_t v);
    exp_t e;
    bus.sSelDecoA    = v.a;
    bus.sSelDecoB    = v.b;
    bus.sSelDecoC    = v.c;
    bus.iPort0       = v.p0;
    bus.iPort1       = v.p1;
    bus.iAluResult   = v.res;
    {bus.iAluOverflow, bus.iAluCarry, bus.iAluNegative, bus.iAluZero} = v.fl;
    #2;
    chk($sformatf("busA sel=%0d", v.a), 32'(bus.oBusA), 32'(m_read(v.a, v.p0, v.p1)));
    chk($sformatf("busB sel=%0d", v.b), 32'(bus.oBusB), 32'(m_read(v.b, v.p0, v.p1)));
    if (v.c <= 3'b101) m_regs[v.c] = v.res;
    if (v.c == 3'b110) m_port = v.res;
    m_valid = (v.c == 3'b110);
    if (v.c != 3'b111) m_flags = v.fl;
    e.port = m_port; e.valid = m_valid; e.flags = m_flags;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("oPortOut", 32'(bus.oPortOut), 32'(e.port));
      chk("oPortValid", 32'(bus.oPortValid), 32'(e.valid));
      chk("flags", 32'(dut_flags()), 32'(e.flags));
    end
  endtask

  vec_t vt[$];

  function automatic vec_t mk(input logic [2:0] a, b, c, input logic [7:0] res,
                              input logic [3:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.p0 = 8'h25; v.p1 = 8'h13; v.res = res; v.fl = fl;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    bus.sSelDecoA = 3'b000; bus.sSelDecoB = 3'b000; bus.sSelDecoC = 3'b111;
    bus.iPort0 = 8'h00; bus.iPort1 = 8'h00; bus.iAluResult = 8'h00;
    {bus.iAluOverflow, bus.iAluCarry, bus.iAluNegative, bus.iAluZero} = 4'b0000;

    // Reset values while held in reset.
    #12;
    chk("rst oPortValid", 32'(bus.oPortValid), 32'd0);
    chk("rst oPortOut", 32'(bus.oPortOut), 32'd0);
    chk("rst flags", 32'(dut_flags()), 32'b0001);
    @(negedge clk);
    lowRst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) vt.push_back(mk(3'(i), 3'(5 - i), 3'b111, 8'hEE, 4'b1111));
    vt.push_back(mk(3'b110, 3'b111, 3'b111, 8'h00, 4'b0000));  // ports on both buses
    vt.push_back(mk(3'b000, 3'b000, 3'b000, 8'h38, 4'b0000));  // write R0, read old
    vt.push_back(mk(3'b000, 3'b110, 3'b111, 8'hFF, 4'b0100));  // no write
    vt.push_back(mk(3'b000, 3'b001, 3'b110, 8'hA5, 4'b0000));  // port write
    vt.push_back(mk(3'b000, 3'b000, 3'b111, 8'h00, 4'b0000));  // strobe drops
    vt.push_back(mk(3'b111, 3'b000, 3'b110, 8'h01, 4'b1010));  // back-to-back port
    vt.push_back(mk(3'b111, 3'b000, 3'b110, 8'h02, 4'b0000));
    vt.push_back(mk(3'b000, 3'b000, 3'b000, 8'h11, 4'b1000));  // strobe drops on reg write
    vt.push_back(mk(3'b001, 3'b001, 3'b001, 8'h00, 4'b0101));  // zero+carry capture
    vt.push_back(mk(3'b001, 3'b000, 3'b111, 8'h77, 4'b0000));  // flags held
    vt.push_back(mk(3'b001, 3'b001, 3'b011, 8'h33, 4'b0010));
    vt.push_back(mk(3'b011, 3'b011, 3'b100, 8'h44, 4'b1001));
    vt.push_back(mk(3'b100, 3'b011, 3'b101, 8'h5A, 4'b0110));
    vt.push_back(mk(3'b101, 3'b100, 3'b010, 8'h55, 4'b0000));
    vt.push_back(mk(3'b010, 3'b101, 3'b110, 8'hC3, 4'b1100));  // R2=55, strobe high next
    foreach (vt[i]) step(vt[i]);

    // Async reset between edges with R2=55 and oPortValid high.
    chk("pre-rst oPortValid", 32'(bus.oPortValid), 32'd1);
    bus.sSelDecoA = 3'b010;
    bus.sSelDecoC = 3'b000;
    bus.iAluResult = 8'h99;
    #2;
    lowRst = 1'b0;
    #1;
    m_reset();
    chk("async busA R2", 32'(bus.oBusA), 32'd0);
    chk("async oPortValid", 32'(bus.oPortValid), 32'd0);
    chk("async oPortOut", 32'(bus.oPortOut), 32'd0);
    chk("async flags", 32'(dut_flags()), 32'b0001);
    // Edge while still in reset must not take the R0 write.
    @(posedge clk);
    #1;
    lowRst = 1'b1;
    q.delete();
    step(mk(3'b000, 3'b010, 3'b111, 8'h00, 4'b0000));
    step(mk(3'b000, 3'b000, 3'b111, 8'h00, 4'b0000));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/reg_bank_io.md
Name: reg_bank_io

Overview:
- Register bank and I/O port stage directly downstream of the sequencing state machine.
- Consumes the decoder selects sSelDecoA, sSelDecoB and sSelDecoC:
  - sSelDecoA and sSelDecoB drive the ALU operand buses.
  - sSelDecoC picks the writeback destination for the ALU result.
- Registers the ALU status flags and feeds them back to the state machine.
- Holds a registered output port with a one-cycle valid strobe.

Parameters:
DATAWIDTH, 8, width of registers, buses and ports
SELECTIONDECO, 3, width of decoder select codes

Ports:
clk  input  1  clock
lowRst  input  1  reset; asynchronous, active-low
sSelDecoA  input  SELECTIONDECO  read select, operand bus A
sSelDecoB  input  SELECTIONDECO  read select, operand bus B
sSelDecoC  input  SELECTIONDECO  write select; 3'b111 = no write
iPort0  input  DATAWIDTH  external input port RP0
iPort1  input  DATAWIDTH  external input port RP1
iAluResult  input  DATAWIDTH  ALU result to write back
iAluOverflow, iAluCarry, iAluNegative, iAluZero  input  1 each  combinational ALU flags
oBusA  output  DATAWIDTH  operand A
oBusB  output  DATAWIDTH  operand B
oPortOut  output  DATAWIDTH  registered output port
oPortValid  output  1  one-cycle strobe, oPortOut updated
sOverflow, sCarry, sNegative, sZero  output  1 each  registered flags to state machine

Behaviour:
- Reset, asynchronous on lowRst=0:
  - R0..R5 = 0, oPortOut = 0, oPortValid = 0.
  - sOverflow = sCarry = sNegative = 0; sZero = 1.
- Read decode, combinational, identical for A and B:
  - 000..101 → R0..R5
  - 110 → iPort0
  - 111 → iPort1
  - Both buses may select the same source.
- Write decode, on posedge clk when lowRst=1:
  - 000..101 → Rn <= iAluResult
  - 110 → oPortOut <= iAluResult, and oPortValid = 1 for the next cycle only
  - 111 → no write
- oPortValid:
  - Is 0 in any cycle after a non-110 write code.
  - Back-to-back 110 codes keep it high one cycle per write.
- Flags:
  - Updated with the iAlu* flags on every clock where sSelDecoC != 111.
  - Held otherwise.
  - Latency: the state machine sees the new flags one cycle after the write cycle.
- Read during write (same cycle, same register):
  - The bus shows the old value.
  - The new value is visible the cycle after.
  - No bypass path.
- Reset mid-operation:
  - All state clears immediately.
  - A write in the same edge as reset release is not taken if lowRst is still low at that edge.
- Width:
  - No arithmetic in this block.
  - iAluResult is stored unmodified: full DATAWIDTH, no truncation or extension.
- Unknown or out-of-range codes: not possible at SELECTIONDECO=3. Wider SELECTIONDECO values above 111 read 0 and do not write.

Decomposition:
- Shared package holds:
  - Decoder code constants: DECO_R0..DECO_R5, DECO_P0 = 3'b110, DECO_P1 = 3'b111, DECO_NOWRITE = 3'b111, DECO_PORTOUT = 3'b110.
  - Flag reset values.
  - These are the same constants the state machine uses.
- One natural sub-module, reg_bank_readmux: combinational read mux. It is instantiated twice, once for A and once for B.
- The write decoder, register array, flag register and port register stay in the top module.

Test Plan:
- Reset then release:
  - All Rn read 0 via A/B codes 000..101; sZero=1, other flags 0; oPortValid=0.
  - iPort0=8'h25, iPort1=8'h13, A=110, B=111 → oBusA=8'h25, oBusB=8'h13 in the same cycle.
- Write R0:
  - C=000, iAluResult=8'h38, flags 0000 → next cycle A=000 reads 8'h38, flags 0000.
  - A=000 in the write cycle itself reads the old value 8'h00.
- No-write code:
  - C=111, iAluResult=8'hFF, iAluCarry=1 → all Rn and flags unchanged; oPortValid stays 0.
- Port write:
  - C=110, iAluResult=8'hA5 → oPortOut=8'hA5 and oPortValid=1 for exactly one cycle.
  - Two consecutive 110 writes (8'h01, 8'h02) → two valid cycles with matching data.
- Flag capture:
  - C=001, iAluResult=8'h00, iAluZero=1, iAluCarry=1 → sZero=1, sCarry=1 next cycle.
  - A following C=111 cycle with all iAlu flags 0 → flags held at 1,1.
- Async reset mid-run:
  - R2=8'h55, oPortValid high → assert lowRst=0 between edges → all outputs return to reset values immediately, without waiting for clk.
